// File: rtl/sm3_arb_pkg.sv
// rtl/sm3_arb_pkg.sv - shared types and constants for the SM3 message arbiter
package sm3_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_XFER      = 3'b010,
        ST_WAIT_DONE = 3'b100
    } arb_state_e;

    localparam int STALL_W   = 12;
    localparam int STALL_MAX = 4095;

    localparam int DW_NARROW = 32;
    localparam int DW_WIDE   = 64;

    function automatic bit dw_legal(input int dw);
        return (dw == DW_NARROW) || (dw == DW_WIDE);
    endfunction

endpackage

// File: rtl/sm3_rr_pick.sv
// rtl/sm3_rr_pick.sv - combinational round-robin selector, first set bit at or above ptr
module sm3_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    // Scan from farthest to nearest so the requester closest to ptr overwrites the rest.
    function automatic logic [ID_W:0] pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
        logic [ID_W:0] s;
        logic [ID_W:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = {1'b0, p} + (ID_W+1)'(i);
            if (s >= (ID_W+1)'(N)) begin
                s = s - (ID_W+1)'(N);
            end
            if (r[s[ID_W-1:0]]) begin
                res = {1'b1, s[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {any, winner} = pick(req, ptr);
    end

endmodule

// File: rtl/sm3_msg_arb.sv
// rtl/sm3_msg_arb.sv - whole-message round-robin arbiter in front of a shared SM3 pad/compress core
module sm3_msg_arb
    import sm3_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int BW      = DW / 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_vld_i,
    input  logic [NUM_REQ*DW-1:0]   req_d_i,
    input  logic [NUM_REQ*BW-1:0]   req_vld_byte_i,
    input  logic [NUM_REQ-1:0]      req_lst_i,
    output logic [NUM_REQ-1:0]      req_rdy_o,
    output logic [DW-1:0]           msg_inpt_d_o,
    output logic [BW-1:0]           msg_inpt_vld_byte_o,
    output logic                    msg_inpt_vld_o,
    output logic                    msg_inpt_lst_o,
    input  logic                    msg_inpt_rdy_i,
    input  logic                    hash_done_i,
    output logic                    res_vld_o,
    output logic [ID_W-1:0]         res_id_o,
    output logic                    busy_o,
    output logic                    err_o
);

    if (!dw_legal(DW)) begin : g_dw_check
        $error("sm3_msg_arb: DW must be 32 or 64");
    end

    arb_state_e         state;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    rr_ptr;
    logic [STALL_W-1:0] stall_cnt;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;
    logic               in_xfer;
    logic               beat_vld;
    logic               beat_xfer;
    logic               stalled;

    sm3_rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req    (req_vld_i),
        .ptr    (rr_ptr),
        .winner (pick_id),
        .any    (pick_any)
    );

    assign in_xfer   = (state == ST_XFER);
    assign beat_vld  = in_xfer && req_vld_i[gnt_id];
    assign beat_xfer = beat_vld && msg_inpt_rdy_i;
    assign stalled   = beat_vld && !msg_inpt_rdy_i;

    // Data-side outputs are forced to zero whenever no beat is offered.
    always_comb begin
        msg_inpt_vld_o      = beat_vld;
        msg_inpt_d_o        = beat_vld ? req_d_i[int'(gnt_id)*DW +: DW] : '0;
        msg_inpt_vld_byte_o = beat_vld ? req_vld_byte_i[int'(gnt_id)*BW +: BW] : '0;
        msg_inpt_lst_o      = beat_vld && req_lst_i[gnt_id];
        req_rdy_o           = in_xfer ? (NUM_REQ'(msg_inpt_rdy_i) << gnt_id) : '0;
        res_vld_o           = (state == ST_WAIT_DONE) && hash_done_i;
        res_id_o            = gnt_id;
        busy_o              = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt_id    <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            err_o     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_id <= pick_id;
                        rr_ptr <= (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (beat_xfer && req_lst_i[gnt_id]) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (hash_done_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Counter saturates; the cycle after it reaches the limit is the first illegal one.
            if (stalled) begin
                if (stall_cnt == STALL_W'(STALL_MAX)) begin
                    err_o <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + STALL_W'(1);
                end
            end else begin
                stall_cnt <= '0;
            end

            if (hash_done_i && state != ST_WAIT_DONE) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sm3_msg_arb.md
Name: sm3_msg_arb

Overview:
- Shares one SM3 padding/compression datapath between NUM_REQ independent message sources.
- Grants the pad-core input stream at whole-message granularity using round-robin order.
- Holds the grant from the first beat until the last beat is accepted, then waits for downstream hash completion.
- Tags each result with the requester ID so results can be routed back to the correct source.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 32, message data width; 32 or 64 only.
- BW, DW/8, byte-valid width.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_vld_i  in  NUM_REQ  per-requester beat valid.
- req_d_i  in  NUM_REQ*DW  per-requester data; requester k occupies bits [k*DW +: DW].
- req_vld_byte_i  in  NUM_REQ*BW  per-requester byte valids; MSB-first packing, meaningful on the last beat.
- req_lst_i  in  NUM_REQ  per-requester last beat of message.
- req_rdy_o  out  NUM_REQ  per-requester ready.
- msg_inpt_d_o  out  DW  data to pad core.
- msg_inpt_vld_byte_o  out  BW  byte valids to pad core.
- msg_inpt_vld_o  out  1  beat valid to pad core.
- msg_inpt_lst_o  out  1  last beat to pad core.
- msg_inpt_rdy_i  in  1  pad-core ready.
- hash_done_i  in  1  single-cycle pulse from the compression engine: digest of the current message is ready.
- res_vld_o  out  1  single-cycle pulse: digest belongs to res_id_o.
- res_id_o  out  ID_W  owner of the completed digest.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset values (sync, rst_n=0 at posedge):
  - state=IDLE, gnt_id=0, rr_ptr=0, err_o=0.
  - All outputs 0.
- State machine (one-hot: IDLE, XFER, WAIT_DONE):
  - IDLE:
    - If any req_vld_i is set, select the first requester with req_vld_i set searching from rr_ptr upward, modulo NUM_REQ.
    - Register gnt_id, set rr_ptr=(winner+1) mod NUM_REQ, go to XFER.
    - Grant latency is 1 cycle; no beat is transferred in IDLE.
  - XFER:
    - msg_inpt_vld_o = req_vld_i[gnt_id].
    - msg_inpt_d_o, msg_inpt_vld_byte_o and msg_inpt_lst_o are muxed from gnt_id; they are 0 when msg_inpt_vld_o=0.
    - req_rdy_o[gnt_id] = msg_inpt_rdy_i; all other req_rdy_o bits are 0.
    - A beat transfers when valid and ready are both high.
    - A transfer with lst=1 moves to WAIT_DONE.
    - The lock is held across valid bubbles; lst=1 on the first beat (single-beat message) is legal.
  - WAIT_DONE:
    - No request is granted; all req_rdy_o bits are 0.
    - On hash_done_i: res_vld_o=1 for that cycle (combinational from hash_done_i and state), res_id_o=gnt_id, next state IDLE.
- Fairness:
  - rr_ptr advances only on a grant.
  - A requester holding req_vld_i continuously is served within NUM_REQ messages.
- res_id_o holds gnt_id in all states; it is only qualified by res_vld_o.
- err_o is set and held until reset when:
  - hash_done_i=1 outside WAIT_DONE; the pulse is ignored and res_vld_o stays 0, or
  - msg_inpt_rdy_i=0 for more than 4095 consecutive cycles in XFER while msg_inpt_vld_o=1 (12-bit stall counter, saturating).
- Requester contract:
  - A requester must not drop req_vld_i mid-message once granted; if it does, only bubbles result.
  - The arbiter never splits a message.
- Simultaneous events: hash_done_i and new requests in the same WAIT_DONE cycle give IDLE first; the new grant follows one cycle later.
- Reset mid-operation: returns to IDLE next edge, the in-flight message is abandoned, rr_ptr=0.

Decomposition:
- Shared package sm3_arb_pkg:
  - state enum/one-hot constants.
  - STALL_MAX=4095.
  - DW legality check constants.
- Sub-module sm3_rr_pick: combinational round-robin priority selector (req vector, ptr -> winner id, any).
- Everything else stays in the top module.

Test Plan:
- Single requester 1, 3-beat message then hash_done_i -> grant at cycle 1, beats appear unchanged, res_vld_o pulse with res_id_o=1, back to IDLE.
- All four requesters valid from reset, each sending 2-beat messages -> grant order 0,1,2,3,0; no interleaving of beats between messages.
- Requester 2 sends a single beat with lst=1 and req_vld_byte_i=4'b1100 (DW=32) -> forwarded with byte valids intact, then WAIT_DONE.
- msg_inpt_rdy_i toggles 1,0,0,1 during a requester 3 message; req_vld_i on other channels -> only req_rdy_o[3] follows ready, others stay 0, data held stable.
- hash_done_i pulsed in IDLE -> err_o=1, res_vld_o=0; rst_n=0 for one edge mid-XFER -> all outputs 0, err_o=0, next grant starts from requester 0.
- DW=64 build: 4-beat message with last-beat req_vld_byte_i=8'hF0 -> exact 64-bit pass-through, res_vld_o after hash_done_i.
